// File: rtl/moore_seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter: state codes,
// default pattern and the output bundle decoded from the FSM state.
package moore_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_SHIFT = 3'b001;
  localparam logic [2:0] ST_GAP   = 3'b010;
  localparam logic [2:0] ST_DONE  = 3'b011;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

  typedef struct packed {
    logic x;
    logic valid;
    logic busy;
    logic done;
  } seq_out_t;

  // Moore output decode: depends only on a state code and the shift-register MSB
  function automatic seq_out_t decode_outputs(input logic [2:0] st, input logic msb_bit);
    seq_out_t o;
    o = '{x: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0};
    case (st)
      ST_SHIFT: o = '{x: msb_bit, valid: 1'b1, busy: 1'b1, done: 1'b0};
      ST_GAP:   o = '{x: 1'b0,    valid: 1'b0, busy: 1'b1, done: 1'b0};
      ST_DONE:  o = '{x: 1'b0,    valid: 1'b0, busy: 1'b0, done: 1'b1};
      default:  o = '{x: 1'b0,    valid: 1'b0, busy: 1'b0, done: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/moore_seq_gen_if.sv
// Request/serial-output bundle between a stimulus controller (master)
// and the pattern transmitter (slave).
interface moore_seq_gen_if #(
  parameter int PATTERN_W = 4,
  parameter int GAP_W     = 4,
  parameter int CNT_W     = 8
);
  import moore_seq_pkg::*;

  logic                 start;
  logic [PATTERN_W-1:0] pattern;
  logic [CNT_W-1:0]     repeat_cnt;
  logic [GAP_W-1:0]     gap;
  logic                 x;
  logic                 valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, pattern, repeat_cnt, gap,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap,
    output x, valid, busy, done
  );

endinterface

// File: rtl/moore_seq_gen_down_counter.sv
// Loadable down-counter; tc flags a count of exactly one so the caller can
// act on the last step. Saturates at zero instead of wrapping.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);
  import moore_seq_pkg::*;

  logic [W-1:0] count_r;

  // Count register: load has priority over decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == W'(1));

endmodule

// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated a
// latched number of times with a latched idle gap, then pulses done.
module moore_seq_gen
  import moore_seq_pkg::*;
#(
  parameter int PATTERN_W = 4,
  parameter int GAP_W     = 4,
  parameter int CNT_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  moore_seq_gen_if.slave bus
);

  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_W - 1);

  logic [2:0]           state_r, next_state_s;
  logic [PATTERN_W-1:0] shreg_r, shreg_next_s;
  logic [PATTERN_W-1:0] pattern_r, pattern_next_s;
  logic [IDX_W-1:0]     bit_idx_r, bit_idx_next_s;
  logic [GAP_W-1:0]     gap_len_r, gap_len_next_s;
  logic                 frm_load_s, frm_dec_s, frm_tc_s;
  logic                 gap_load_s, gap_dec_s, gap_tc_s;
  seq_out_t             out_next_s, out_r;

  seq_down_counter #(.W(CNT_W)) u_frames_left (
    .clk      (clk),
    .rst      (rst),
    .load     (frm_load_s),
    .load_val (bus.repeat_cnt),
    .dec      (frm_dec_s),
    .tc       (frm_tc_s)
  );

  seq_down_counter #(.W(GAP_W)) u_gap_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load_s),
    .load_val (gap_len_r),
    .dec      (gap_dec_s),
    .tc       (gap_tc_s)
  );

  // Next-state and datapath update logic
  always_comb begin
    next_state_s   = state_r;
    shreg_next_s   = shreg_r;
    pattern_next_s = pattern_r;
    bit_idx_next_s = bit_idx_r;
    gap_len_next_s = gap_len_r;
    frm_load_s     = 1'b0;
    frm_dec_s      = 1'b0;
    gap_load_s     = 1'b0;
    gap_dec_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          pattern_next_s = bus.pattern;
          shreg_next_s   = bus.pattern;
          gap_len_next_s = bus.gap;
          bit_idx_next_s = LAST_IDX;
          frm_load_s     = 1'b1;
          if (bus.repeat_cnt == '0) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_SHIFT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_next_s   = {shreg_r[PATTERN_W-2:0], 1'b0};
        bit_idx_next_s = bit_idx_r - IDX_W'(1);
        if (bit_idx_r == '0) begin
          // frm_tc_s reflects the count before this frame's decrement
          frm_dec_s      = 1'b1;
          bit_idx_next_s = LAST_IDX;
          if (frm_tc_s) begin
            next_state_s = ST_DONE;
          end else if (gap_len_r == '0) begin
            shreg_next_s = pattern_r;
            next_state_s = ST_SHIFT;
          end else begin
            gap_load_s   = 1'b1;
            next_state_s = ST_GAP;
          end
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_GAP: begin
        gap_dec_s = 1'b1;
        if (gap_tc_s) begin
          shreg_next_s   = pattern_r;
          bit_idx_next_s = LAST_IDX;
          next_state_s   = ST_SHIFT;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they match the state in the same cycle
  always_comb begin
    out_next_s = decode_outputs(next_state_s, shreg_next_s[PATTERN_W-1]);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      pattern_r <= '0;
      bit_idx_r <= '0;
      gap_len_r <= '0;
      out_r     <= '{x: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0};
    end else begin
      state_r   <= next_state_s;
      shreg_r   <= shreg_next_s;
      pattern_r <= pattern_next_s;
      bit_idx_r <= bit_idx_next_s;
      gap_len_r <= gap_len_next_s;
      out_r     <= out_next_s;
    end
  end

  assign bus.x     = out_r.x;
  assign bus.valid = out_r.valid;
  assign bus.busy  = out_r.busy;
  assign bus.done  = out_r.done;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Self-checking bench for moore_seq_gen: directed table, random transfers
// against a frame-level reference model, and reset/ignored-start sequences.
module tb_moore_seq_gen;
  import moore_seq_pkg::*;

  localparam int PW = 4;
  localparam int GW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  moore_seq_gen_if #(.PATTERN_W(PW), .GAP_W(GW), .CNT_W(CW)) bus();

  moore_seq_gen #(.PATTERN_W(PW), .GAP_W(GW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [PW-1:0] pat;
    int            rep;
    int            gp;
    int            exp_done;
    int            exp_valid;
    int            exp_det;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: per-cycle {x,valid,busy,done} after start, built frame by frame
  task automatic model(input logic [PW-1:0] pat, input int rep, input int gp);
    exp_q.delete();
    for (int f = 0; f < rep; f++) begin
      for (int b = PW - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      if (f < rep - 1)
        for (int g = 0; g < gp; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run_case(input string tag, input logic [PW-1:0] pat, input int rep,
                          input int gp, input bit disturb,
                          output int done_at, output int valid_cnt, output int det_cnt);
    logic [3:0] win;
    int len;
    model(pat, rep, gp);
    bus.pattern    = pat;
    bus.repeat_cnt = CW'(rep);
    bus.gap        = GW'(gp);
    bus.start      = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_at = 0; valid_cnt = 0; det_cnt = 0; win = 4'b0000;
    len = exp_q.size();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, i + 1), {bus.x, bus.valid, bus.busy, bus.done}, exp_q[i]);
      if (bus.done && done_at == 0) done_at = i + 1;
      if (bus.valid) valid_cnt++;
      // non-overlapping 1010 detector fed from the serial line while busy
      if (bus.busy) begin
        win = {win[2:0], bus.x};
        if (win == 4'b1010) begin
          det_cnt++;
          win = 4'b0000;
        end
      end
      if (disturb && i == 1) begin
        bus.start      = 1'b1;
        bus.pattern    = ~pat;
        bus.repeat_cnt = 8'd7;
        bus.gap        = 4'd5;
      end
      if (disturb && i == 2) bus.start = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d, v, t;
    logic [PW-1:0] rp;
    int rr, rg;

    rst = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.repeat_cnt = '0; bus.gap = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle hold %0d", i), {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    end

    vecs[0] = '{4'b1010, 1, 0, 5, 4, 1};
    vecs[1] = '{4'b1010, 3, 2, 17, 12, 3};
    vecs[2] = '{4'b1100, 2, 0, 9, 8, 0};
    vecs[3] = '{4'b1111, 0, 3, 1, 0, 0};
    for (int k = 0; k < 4; k++) begin
      run_case($sformatf("vec%0d", k), vecs[k].pat, vecs[k].rep, vecs[k].gp, 1'b0, d, v, t);
      check($sformatf("vec%0d done cycle", k), d, vecs[k].exp_done);
      check($sformatf("vec%0d valid count", k), v, vecs[k].exp_valid);
      check($sformatf("vec%0d detections", k), t, vecs[k].exp_det);
    end

    for (int k = 0; k < 20; k++) begin
      rp = PW'($urandom);
      rr = $urandom_range(0, 4);
      rg = $urandom_range(0, 3);
      run_case($sformatf("rnd%0d", k), rp, rr, rg, 1'b0, d, v, t);
      check($sformatf("rnd%0d done cycle", k), d, (rr == 0) ? 1 : rr * PW + (rr - 1) * rg + 1);
    end

    run_case("maxgap", 4'b1001, 2, 15, 1'b0, d, v, t);
    check("maxgap done cycle", d, 2 * PW + 15 + 1);
    run_case("maxrep", 4'b1011, 255, 0, 1'b0, d, v, t);
    check("maxrep valid count", v, 255 * PW);

    run_case("zero rep", 4'b1010, 0, 1, 1'b0, d, v, t);
    run_case("ignored start", 4'b1010, 2, 1, 1'b1, d, v, t);
    check("ignored start valid count", v, 2 * PW);

    // reset during the 3rd bit of frame 2
    bus.pattern = 4'b1010; bus.repeat_cnt = 8'd3; bus.gap = 4'd0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid-frame valid", bus.valid, 1'b1);
    #1 rst = 1'b1;
    #1 check("async reset outputs", {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in reset %0d", i), {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("post reset %0d", i), {bus.x, bus.valid, bus.busy, bus.done}, 4'b0000);
    end
    run_case("after reset", 4'b1010, 3, 0, 1'b0, d, v, t);
    check("after reset detections", t, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
